// File: rtl/cache_pkg.sv
// Shared constants, FSM encoding and address-field helpers for the data cache.
package cache_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned INDEX_W   = 4;
    localparam int unsigned TAG_W     = 26;
    localparam int unsigned INDEX_LSB = 2;
    localparam int unsigned TAG_LSB   = INDEX_LSB + INDEX_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REFILL     = 2'd1,
        WRITE_THRU = 2'd2
    } state_t;

    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
        return a[INDEX_LSB +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
        return a[TAG_LSB +: TAG_W];
    endfunction

endpackage

// File: rtl/cache_array.sv
// Tag/data/valid storage: one combinational read port, one synchronous write port.
module cache_array
    import cache_pkg::*;
#(
    parameter int unsigned LINES = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [INDEX_W-1:0] i_rd_index,
    output logic               o_rd_valid,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic [DATA_W-1:0]  o_rd_data,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [DATA_W-1:0]  i_wr_data
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Valid bits: cleared asynchronously, set by any line write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tag and data storage, unreset; stale contents are masked by valid.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through / no-write-allocate data cache for the MEM stage.
module data_cache
    import cache_pkg::*;
#(
    parameter int unsigned LINES  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clockPulse,
    input  logic              resetN,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    output logic              hit,
    output logic [DATA_W-1:0] readData,
    output logic              stall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memReady,
    input  logic [DATA_W-1:0] memRData
);

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               w_latch;

    logic               w_rd_valid;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_tag_match;

    logic               w_we;
    logic [INDEX_W-1:0] w_wr_index;
    logic [TAG_W-1:0]   w_wr_tag;
    logic [DATA_W-1:0]  w_wr_data;

    cache_array #(
        .LINES (LINES)
    ) u_array (
        .i_clk      (clockPulse),
        .i_rst_n    (resetN),
        .i_rd_index (addr_index(address)),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_we       (w_we),
        .i_wr_index (w_wr_index),
        .i_wr_tag   (w_wr_tag),
        .i_wr_data  (w_wr_data)
    );

    assign w_tag_match = w_rd_valid && (w_rd_tag == addr_tag(address));

    // State register.
    always_ff @(posedge clockPulse or negedge resetN) begin
        if (!resetN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch, captured when IDLE hands off to a memory transaction.
    always_ff @(posedge clockPulse or negedge resetN) begin
        if (!resetN) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_latch) begin
            r_addr  <= address;
            r_wdata <= writeData;
        end
    end

    // Next state, handshake outputs and the single array write port.
    // Store hits and refill completions share the write port; a store hit
    // rewrites the matching tag, which leaves the tag unchanged.
    always_comb begin
        w_next     = r_state;
        hit        = 1'b0;
        stall      = 1'b0;
        memReq     = 1'b0;
        memWe      = 1'b0;
        w_latch    = 1'b0;
        w_we       = 1'b0;
        w_wr_index = addr_index(address);
        w_wr_tag   = addr_tag(address);
        w_wr_data  = writeData;
        case (r_state)
            IDLE: begin
                if (MemWrite) begin
                    stall   = 1'b1;
                    w_latch = 1'b1;
                    w_we    = w_tag_match;
                    w_next  = WRITE_THRU;
                end else if (MemRead) begin
                    if (w_tag_match) begin
                        hit = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        w_latch = 1'b1;
                        w_next  = REFILL;
                    end
                end
            end
            REFILL: begin
                stall      = 1'b1;
                memReq     = 1'b1;
                w_wr_index = addr_index(r_addr);
                w_wr_tag   = addr_tag(r_addr);
                w_wr_data  = memRData;
                if (memReady) begin
                    w_we   = 1'b1;
                    w_next = IDLE;
                end
            end
            WRITE_THRU: begin
                stall  = 1'b1;
                memReq = 1'b1;
                memWe  = 1'b1;
                if (memReady) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign readData = hit ? w_rd_data : '0;
    assign memAddr  = r_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
    assign memWData = r_wdata;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios then random traffic
// against a line-level reference model of the cache contents.
module tb_data_cache;

    logic        clockPulse = 1'b0;
    logic        resetN     = 1'b0;
    logic        MemRead    = 1'b0;
    logic        MemWrite   = 1'b0;
    logic [31:0] address    = '0;
    logic [31:0] writeData  = '0;
    logic        hit;
    logic [31:0] readData;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic        memReady   = 1'b0;
    logic [31:0] memRData   = '0;

    data_cache #(
        .LINES  (16),
        .ADDR_W (32)
    ) dut (
        .clockPulse (clockPulse),
        .resetN     (resetN),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .address    (address),
        .writeData  (writeData),
        .hit        (hit),
        .readData   (readData),
        .stall      (stall),
        .memReq     (memReq),
        .memWe      (memWe),
        .memAddr    (memAddr),
        .memWData   (memWData),
        .memReady   (memReady),
        .memRData   (memRData)
    );

    always #5 clockPulse = ~clockPulse;

    // Reference contents: one word per line, tag = addr/64, line = (addr/4) mod 16.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic int unsigned line_of(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic logic [25:0] tag_of(input logic [31:0] a);
        return 26'(a / 64);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[line_of(a)] && (m_tag[line_of(a)] == tag_of(a));
    endfunction

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle_cycle();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        memReady = 1'($urandom);
        memRData = $urandom;
        @(negedge clockPulse);
        chk("idle_hit",    32'(hit),    32'd0);
        chk("idle_stall",  32'(stall),  32'd0);
        chk("idle_memreq", 32'(memReq), 32'd0);
        @(posedge clockPulse); #1;
        memReady = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int lat, input logic [31:0] rd);
        bit          exp_hit;
        int unsigned ln;
        exp_hit  = model_hit(a);
        ln       = line_of(a);
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        address  = a;
        writeData = $urandom;
        @(negedge clockPulse);
        chk("rd_hit",    32'(hit),    32'(exp_hit));
        chk("rd_stall",  32'(stall),  32'(!exp_hit));
        chk("rd_data",   readData,    exp_hit ? m_data[ln] : 32'd0);
        chk("rd_memreq", 32'(memReq), 32'd0);
        if (!exp_hit) begin
            @(posedge clockPulse); #1;
            for (int k = 0; k <= lat; k++) begin
                if (k == lat) begin
                    memReady = 1'b1;
                    memRData = rd;
                end else begin
                    memRData = $urandom;
                end
                @(negedge clockPulse);
                chk("rf_memreq", 32'(memReq), 32'd1);
                chk("rf_memwe",  32'(memWe),  32'd0);
                chk("rf_addr",   memAddr,     a & ~32'd3);
                chk("rf_stall",  32'(stall),  32'd1);
                chk("rf_hit",    32'(hit),    32'd0);
                @(posedge clockPulse); #1;
            end
            memReady   = 1'b0;
            m_valid[ln] = 1'b1;
            m_tag[ln]   = tag_of(a);
            m_data[ln]  = rd;
            @(negedge clockPulse);
            chk("retry_hit",   32'(hit),   32'd1);
            chk("retry_data",  readData,   rd);
            chk("retry_stall", 32'(stall), 32'd0);
        end
        @(posedge clockPulse); #1;
        MemRead = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit both, input int lat);
        MemWrite  = 1'b1;
        MemRead   = both;
        address   = a;
        writeData = d;
        @(negedge clockPulse);
        chk("wr_hit",    32'(hit),    32'd0);
        chk("wr_stall",  32'(stall),  32'd1);
        chk("wr_memreq", 32'(memReq), 32'd0);
        @(posedge clockPulse); #1;
        if (model_hit(a)) m_data[line_of(a)] = d;
        // The pipeline is stalled; whatever it presents now must be ignored.
        address   = $urandom;
        writeData = $urandom;
        MemRead   = 1'($urandom);
        MemWrite  = 1'($urandom);
        for (int k = 0; k <= lat; k++) begin
            memReady = (k == lat);
            @(negedge clockPulse);
            chk("wt_memreq", 32'(memReq), 32'd1);
            chk("wt_memwe",  32'(memWe),  32'd1);
            chk("wt_addr",   memAddr,     a & ~32'd3);
            chk("wt_wdata",  memWData,    d);
            chk("wt_stall",  32'(stall),  32'd1);
            @(posedge clockPulse); #1;
        end
        memReady = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(negedge clockPulse);
        chk("wt_done_stall",  32'(stall),  32'd0);
        chk("wt_done_memreq", 32'(memReq), 32'd0);
        @(posedge clockPulse); #1;
    endtask

    task automatic reset_mid_refill(input logic [31:0] a);
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        address  = a;
        @(negedge clockPulse);
        chk("rst_pre_stall", 32'(stall), 32'd1);
        @(posedge clockPulse); #1;
        @(negedge clockPulse);
        chk("rst_in_refill", 32'(memReq), 32'd1);
        #2;
        resetN  = 1'b0;
        MemRead = 1'b0;
        #1;
        chk("rst_memreq", 32'(memReq), 32'd0);
        chk("rst_stall",  32'(stall),  32'd0);
        chk("rst_hit",    32'(hit),    32'd0);
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        // A memReady during reset must not complete the abandoned refill.
        memReady = 1'b1;
        memRData = 32'hDEAD_BEEF;
        @(posedge clockPulse); #1;
        memReady = 1'b0;
        resetN   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        int          op;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;

        // Reset state.
        repeat (2) @(posedge clockPulse);
        @(negedge clockPulse);
        chk("reset_hit",    32'(hit),    32'd0);
        chk("reset_stall",  32'(stall),  32'd0);
        chk("reset_memreq", 32'(memReq), 32'd0);
        chk("reset_maddr",  memAddr,     32'd0);
        chk("reset_mwdata", memWData,    32'd0);
        @(posedge clockPulse); #1;
        resetN = 1'b1;
        idle_cycle();

        // Directed scenarios.
        do_read(32'h40, 3, 32'h0000_000E);
        do_write(32'h40, 32'h10, 1'b0, 2);
        do_read(32'h40, 0, 32'h0);
        do_write(32'h80, 32'h99, 1'b0, 1);
        do_read(32'h40, 0, 32'h0);
        do_read(32'h80, 1, 32'h06);
        do_read(32'h40, 0, 32'h10);
        do_write(32'h44, 32'h55, 1'b1, 0);
        do_read(32'h47, 2, 32'h1234_5678);
        do_write(32'h46, 32'hAA, 1'b1, 0);
        do_read(32'h44, 0, 32'h0);
        idle_cycle();
        reset_mid_refill(32'h100);
        do_read(32'h100, 0, 32'h77);
        do_read(32'h40, 1, 32'h21);
        do_read(32'h44, 1, 32'h22);

        // Random traffic over a small tag pool so hits and conflicts both occur.
        for (int n = 0; n < 250; n++) begin
            a  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
            op = $urandom_range(0, 9);
            if (op <= 4)      do_read(a, $urandom_range(0, 3), $urandom);
            else if (op <= 7) do_write(a, $urandom, 1'b0, $urandom_range(0, 3));
            else if (op == 8) do_write(a, $urandom, 1'b1, $urandom_range(0, 3));
            else              idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): LINES, 16, direct-mapped lines of one 32-bit word each; ADDR_W, 32, byte-address width.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
 clockPulse  in  1  the single clock; all state updates on its rising edge.
 resetN  in  1  asynchronous, active-low reset.
 MemRead  in  1  load request from the MEM stage.
 MemWrite  in  1  store request from the MEM stage.
 address  in  32  word-aligned byte address; bits [1:0] are ignored.
 writeData  in  32  store data.
 hit  out  1  lookup hit, feeds the hit input of MEM/WB.
 readData  out  32  load data, feeds readData of MEM/WB.
 stall  out  1  holds the pipeline, including MEM/WB.
 memReq  out  1  request to main memory.
 memWe  out  1  1 = memory write, 0 = memory refill read.
 memAddr  out  32  memory word address.
 memWData  out  32  memory write data.
 memReady  in  1  memory acknowledge; memRData is valid in the same cycle.
 memRData  in  32  refill data.
REQ-003 Address split: index = address[5:2]; tag = address[31:6] (26 bits).

Function
REQ-004 The controller SHALL have three FSM states: IDLE, REFILL and WRITE_THRU.
REQ-005 In IDLE, lookup SHALL be combinational: hit = MemRead & valid[index] & (tag[index] == address tag), and readData = data[index] when hit is 1, else 0.
REQ-006 IDLE with MemRead=1 and hit=0 SHALL assert stall the same cycle and go to REFILL on the next edge, latching address.
REQ-007 In REFILL: memReq=1, memWe=0, memAddr = latched address with bits [1:0]=0, stall=1.
REQ-008 In REFILL on the edge where memReady=1, the controller SHALL write memRData, the latched tag and valid=1 into the line, then return to IDLE.
REQ-009 After a refill, the repeated lookup in IDLE SHALL hit: the miss-to-hit penalty is the memory latency plus 1 cycle.
REQ-010 IDLE with MemWrite=1 SHALL use write-through with no-write-allocate: on tag match with valid set, update data[index] on the next edge; otherwise leave the line unchanged. The FSM SHALL then go to WRITE_THRU, latching address and writeData.
REQ-011 In WRITE_THRU: memReq=1, memWe=1, memAddr and memWData from the latched values, stall=1; on memReady=1 return to IDLE.
REQ-012 IDLE with MemWrite=1 SHALL assert stall combinationally, and hit SHALL be 0 for stores.
REQ-013 If MemRead and MemWrite are both 1, MemWrite SHALL take priority, and hit SHALL be 0.
REQ-014 In IDLE with no request: memReq=0, stall=0, hit=0.
REQ-015 memReq SHALL stay high with stable memAddr, memWe and memWData until memReady is seen; memReady outside REFILL or WRITE_THRU SHALL be ignored.
REQ-016 A memReady that arrives in the first cycle of REFILL or WRITE_THRU SHALL be honoured, giving a minimum transaction of 1 cycle.
REQ-017 Inputs SHALL be ignored outside IDLE, because the pipeline is stalled.

Reset
REQ-018 resetN=0 SHALL asynchronously force state=IDLE and clear every valid bit. Registered outputs and latches SHALL clear to 0, so hit, stall and memReq are 0.
REQ-019 Reset during REFILL SHALL abandon the refill with no line written. Reset during WRITE_THRU SHALL abandon the write; memory consistency is then the system's responsibility.
REQ-020 Tag and data arrays need not be reset; valid=0 SHALL mask them.

Structure
REQ-021 A shared package cache_pkg SHALL hold INDEX_W=4, TAG_W=26, the state encoding (IDLE=2'd0, REFILL=2'd1, WRITE_THRU=2'd2) and the address-field slicing constants.
REQ-022 The tag, data and valid storage SHALL be a sub-module cache_array: one combinational read port and one synchronous write port, with the valid bits held in flops that reset asynchronously.

Verification
REQ-023 After reset, a MemRead at 0x40 SHALL give hit=0 and stall=1 in the same cycle, then memReq=1 with memAddr=0x40.
REQ-024 With memReady=1 and memRData=0x0000000E after 3 cycles, the bench SHALL see return to IDLE, then hit=1, readData=0x0E and stall=0 on the retry.
REQ-025 A MemWrite of 0x10 to 0x40, which is cached, SHALL produce a line update, memWe=1, memWData=0x10 and stall until memReady; a following read of 0x40 SHALL hit with 0x10.
REQ-026 A MemWrite to 0x80, which maps to the same index as 0x40 with a different tag, SHALL leave the line unchanged; a read of 0x40 SHALL still hit with 0x10.
REQ-027 A conflicting read at 0x80 SHALL miss and refill with 0x06; a read of 0x40 SHALL then miss.
REQ-028 Pulling resetN low mid-REFILL SHALL immediately give memReq=0 and stall=0, and every following read SHALL miss.
